// File: rtl/mul_div_unit.sv
// Iterative RV32M multiply/divide unit: 32-cycle shift-add multiply and
// restoring divide on operand magnitudes, with the sign applied on the last edge.
module mul_div_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [2:0]  command,
  input  logic [31:0] src1,
  input  logic [31:0] src2,
  input  logic        flush,
  output logic        busy,
  output logic        done,
  output logic [31:0] result
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;
  typedef enum logic [2:0] {
    CMD_MUL, CMD_MULH, CMD_MULHSU, CMD_MULHU,
    CMD_DIV, CMD_DIVU, CMD_REM, CMD_REMU
  } cmd_t;

  state_t      r_state;
  logic [2:0]  r_cmd;
  logic [31:0] r_a;
  logic [31:0] r_b;
  logic [63:0] r_acc;
  logic [31:0] r_rem;
  logic [4:0]  r_cnt;
  logic        r_sign;
  logic        r_spec;
  logic [31:0] r_spec_val;
  logic        r_busy;
  logic        r_done;
  logic [31:0] r_result;

  logic        w_s1_signed, w_s2_signed, w_neg1, w_neg2, w_sign;
  logic [31:0] w_mag1, w_mag2;
  logic        w_div0, w_ovf;
  logic [31:0] w_spec_val;
  logic [32:0] w_mul_sum;
  logic [63:0] w_mul_next;
  logic [32:0] w_rem_sh;
  logic        w_ge;
  logic [31:0] w_rem_sub, w_rem_next, w_quo_next;
  logic [31:0] w_prod_hi, w_quo_fix, w_rem_fix, w_final;

  // Start-time decode: operand magnitudes, result sign and special cases.
  always_comb begin
    w_s1_signed = (command == CMD_MULH) || (command == CMD_MULHSU) ||
                  (command == CMD_DIV)  || (command == CMD_REM);
    w_s2_signed = (command == CMD_MULH) || (command == CMD_DIV) ||
                  (command == CMD_REM);
    w_neg1 = w_s1_signed & src1[31];
    w_neg2 = w_s2_signed & src2[31];
    w_mag1 = w_neg1 ? (~src1 + 32'd1) : src1;
    w_mag2 = w_neg2 ? (~src2 + 32'd1) : src2;
    case (command)
      CMD_MULH, CMD_DIV:   w_sign = w_neg1 ^ w_neg2;
      CMD_MULHSU, CMD_REM: w_sign = w_neg1;
      default:             w_sign = 1'b0;
    endcase
    w_div0 = command[2] && (src2 == '0);
    w_ovf  = ((command == CMD_DIV) || (command == CMD_REM)) &&
             (src1 == 32'h8000_0000) && (src2 == '1);
    if (w_div0)
      w_spec_val = command[1] ? src1 : '1;
    else
      w_spec_val = command[1] ? '0 : 32'h8000_0000;
  end

  // One iteration: multiply keeps the multiplier in r_acc[31:0] and shifts the
  // product in from the top; divide shifts the dividend out of r_acc[31:0].
  always_comb begin
    w_mul_sum  = {1'b0, r_acc[63:32]} + {1'b0, (r_acc[0] ? r_a : 32'd0)};
    w_mul_next = {w_mul_sum, r_acc[31:1]};
    w_rem_sh   = {r_rem, r_acc[31]};
    w_ge       = w_rem_sh >= {1'b0, r_b};
    w_rem_sub  = w_rem_sh[31:0] - r_b;
    w_rem_next = w_ge ? w_rem_sub : w_rem_sh[31:0];
    w_quo_next = {r_acc[30:0], w_ge};
    // High word of the negated 64-bit product: borrow in only when low word is 0.
    w_prod_hi  = r_sign ? (~w_mul_next[63:32] + {31'd0, (w_mul_next[31:0] == '0)})
                        : w_mul_next[63:32];
    w_quo_fix  = r_sign ? (~w_quo_next + 32'd1) : w_quo_next;
    w_rem_fix  = r_sign ? (~w_rem_next + 32'd1) : w_rem_next;
    if (r_spec)
      w_final = r_spec_val;
    else begin
      case (r_cmd)
        CMD_MUL:                        w_final = w_mul_next[31:0];
        CMD_MULH, CMD_MULHSU, CMD_MULHU: w_final = w_prod_hi;
        CMD_DIV, CMD_DIVU:              w_final = w_quo_fix;
        default:                        w_final = w_rem_fix;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_cmd      <= '0;
      r_a        <= '0;
      r_b        <= '0;
      r_acc      <= '0;
      r_rem      <= '0;
      r_cnt      <= '0;
      r_sign     <= 1'b0;
      r_spec     <= 1'b0;
      r_spec_val <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_result   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (enable && !flush) begin
            r_state    <= S_RUN;
            r_busy     <= 1'b1;
            r_cmd      <= command;
            r_a        <= w_mag1;
            r_b        <= w_mag2;
            r_acc      <= {32'd0, (command[2] ? w_mag1 : w_mag2)};
            r_rem      <= '0;
            r_cnt      <= '0;
            r_sign     <= w_sign;
            r_spec     <= w_div0 | w_ovf;
            r_spec_val <= w_spec_val;
          end
        end
        S_RUN: begin
          if (flush) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_cnt <= r_cnt + 5'd1;
            r_acc <= r_cmd[2] ? {32'd0, w_quo_next} : w_mul_next;
            r_rem <= w_rem_next;
            if (r_cnt == 5'd31) begin
              r_state  <= S_DONE;
              r_done   <= 1'b1;
              r_result <= w_final;
            end
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    busy   = r_busy;
    done   = r_done;
    result = r_result;
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed-vector bench for mul_div_unit with hand-computed expected results.
module tb_mul_div_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic [2:0]  command;
  logic [31:0] src1;
  logic [31:0] src2;
  logic        flush;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int n_checks = 0;
  int n_errors = 0;
  int n_pulses = 0;
  int snap;

  mul_div_unit dut (
    .clk    (clk),
    .rst    (rst),
    .enable (enable),
    .command(command),
    .src1   (src1),
    .src2   (src2),
    .flush  (flush),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (done) n_pulses++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Holds enable across one rising edge (E0); returns at the negedge of cycle 1.
  task automatic issue(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    enable  = 1'b1;
    command = c;
    src1    = a;
    src2    = b;
    @(negedge clk);
    enable  = 1'b0;
  endtask

  task automatic wait_done(input string tag, input logic [31:0] exp, input int c0);
    int c;
    c = c0;
    while (!done && c < 100) begin
      @(negedge clk);
      c++;
    end
    check({tag, "_lat"}, c, 33);
    check({tag, "_res"}, result, exp);
    check({tag, "_busy"}, {31'd0, busy}, 32'd1);
    @(negedge clk);
    check({tag, "_idle"}, {30'd0, busy, done}, 32'd0);
    check({tag, "_hold"}, result, exp);
  endtask

  task automatic run_op(input string tag, input logic [2:0] c, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp);
    issue(c, a, b);
    wait_done(tag, exp, 1);
  endtask

  initial begin
    rst = 1'b0; enable = 1'b0; command = '0; src1 = '0; src2 = '0; flush = 1'b0;
    #12;
    check("rst_out", {busy, done, result[29:0]}, 32'd0);
    check("rst_res", result, 32'd0);
    @(negedge clk);
    rst = 1'b1;

    run_op("mul",    3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB);
    run_op("mulh",   3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000);
    run_op("mulhsu", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op("mulhu",  3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    run_op("div",    3'd4, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD);
    run_op("rem",    3'd6, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF);
    run_op("divu",   3'd5, 32'd100,       32'd7,         32'd14);
    run_op("remu",   3'd7, 32'd100,       32'd7,         32'd2);
    run_op("div_ovf",3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
    run_op("rem_ovf",3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0);
    run_op("div_z",  3'd4, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFFF);
    run_op("divu_z", 3'd5, 32'd5,         32'd0,         32'hFFFF_FFFF);
    run_op("remu_z", 3'd7, 32'd5,         32'd0,         32'd5);

    // flush together with enable in IDLE: no start
    @(negedge clk);
    enable = 1'b1; flush = 1'b1; command = 3'd0; src1 = 32'd9; src2 = 32'd9;
    @(negedge clk);
    enable = 1'b0; flush = 1'b0;
    check("flush_en_idle", {31'd0, busy}, 32'd0);

    // flush at RUN iteration 10, restart two cycles later
    snap = n_pulses;
    issue(3'd0, 32'd5, 32'd6);
    repeat (10) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_busy", {30'd0, busy, done}, 32'd0);
    check("flush_hold", result, 32'd5);
    run_op("restart", 3'd0, 32'd3, 32'd4, 32'd12);
    check("flush_pulses", n_pulses - snap, 32'd1);

    // enable at iteration 5 while busy is ignored
    snap = n_pulses;
    issue(3'd5, 32'd100, 32'd7);
    repeat (5) @(negedge clk);
    enable = 1'b1; command = 3'd0; src1 = 32'd11; src2 = 32'd13;
    @(negedge clk);
    enable = 1'b0;
    wait_done("busy_ign", 32'd14, 7);
    repeat (40) @(negedge clk);
    check("busy_pulses", n_pulses - snap, 32'd1);
    check("busy_hold", result, 32'd14);

    // asynchronous reset mid-RUN, away from any clock edge
    issue(3'd0, 32'd3, 32'd4);
    repeat (10) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("arst_flags", {30'd0, busy, done}, 32'd0);
    check("arst_res", result, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    run_op("div_post", 3'd4, 32'd9, 32'd3, 32'd3);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/mul_div_unit.md
# mul_div_unit

Iterative RV32M multiply/divide execution unit. It accepts one operation at a time from the execute stage when the decoded op has `exUnitType == ExUnitType_MulDiv`. It consumes the `MulDivCommand` field of the decoded op's command union and returns a 32-bit result for integer register writeback. Every command has a fixed latency, so issue logic stays simple and the bench stays deterministic.

## Interface
Parameters:
- none; the data width is fixed at 32 (`word_t`).

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `enable`  in  1  start request; sampled only in IDLE.
- `command`  in  3  `MulDivCommand` value:
  - Mul=0, Mulh=1, Mulhsu=2, Mulhu=3
  - Div=4, Divu=5, Rem=6, Remu=7
- `src1`  in  32  rs1 operand (multiplicand or dividend).
- `src2`  in  32  rs2 operand (multiplier or divisor).
- `flush`  in  1  aborts any in-flight operation.
- `busy`  out  1  high in RUN and DONE.
- `done`  out  1  one-cycle pulse; `result` is valid in this cycle.
- `result`  out  32  operation result.

## Operation
- **States:** IDLE, RUN, DONE.
- **IDLE → RUN:** on an edge with `enable=1` and `flush=0`.
  - Latch `command`.
  - Latch |src1| and |src2| as magnitudes. A source is signed when:
    - src1: Mulh, Mulhsu, Div, Rem
    - src2: Mulh, Div, Rem
  - Latch the result sign:
    - Mulh, Div: neg1^neg2
    - Mulhsu: neg1
    - Rem: neg1
    - unsigned commands: 0
  - Clear the 5-bit iteration counter.
- **RUN:** 32 iterations, one per edge, counter 0..31.
  - Multiply: radix-2 shift-add into a 64-bit accumulator.
  - Divide: restoring, 1 quotient bit per cycle, 33-bit partial remainder.
- **RUN → DONE:** on the edge where counter==31. On that same edge, apply the sign fix-up and select the result:
  - Mul: product[31:0].
  - Mulh, Mulhsu, Mulhu: product[63:32], after 64-bit two's-complement negation when sign=1.
  - Div, Divu: quotient, negated when sign=1.
  - Rem, Remu: remainder, negated when sign=1.
- **Special cases** override the iterative result. They are detected at start, and latency is unchanged:
  - Divisor 0: Div/Divu → 0xFFFFFFFF; Rem/Remu → src1 unmodified.
  - Div with src1=0x80000000 and src2=0xFFFFFFFF → 0x80000000; Rem with the same operands → 0.
- **DONE → IDLE:** unconditionally on the next edge.
- **Flush:**
  - `flush=1` in RUN or DONE → IDLE on the next edge.
  - If `done` was high in that cycle, the pulse still occurs, but the consumer treats the result as discarded.
  - `flush` and `enable` together in IDLE: flush wins and there is no start.
- **Ignored start:** `enable` while `busy=1` is ignored; no queuing.
- **Result hold:** `result` is held from DONE until the next accepted start. It is undefined-free: it never changes while IDLE.
- **Reset:**
  - Applies immediately and asynchronously in any state.
  - State → IDLE; `busy`, `done` and `result` → 0.
  - All internal registers → 0.

## Timing
- Start sampled on edge E0. RUN spans E1..E32. `done`=1 during the cycle following E32, which is 33 cycles after the start cycle.
- `busy` rises after E0 and falls after E33 (the DONE→IDLE edge).
- Back-to-back operation: the earliest next start is sampled on E33, while `busy` is still high from DONE. That start is ignored, so the first accepted restart is at E34 or later.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Test plan
- **Multiplies:**
  - Mul 7 × 0xFFFFFFFD → 0xFFFFFFEB.
  - Mulh 0x80000000 × 0x80000000 → 0x40000000.
  - Mulhsu 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFF.
  - Mulhu 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE.
  - Each with `done` exactly 33 cycles after start.
- **Signed/unsigned divides:**
  - Div 0xFFFFFFF9 / 2 → 0xFFFFFFFD.
  - Rem → 0xFFFFFFFF.
  - Divu 100/7 → 14.
  - Remu → 2.
- **Special cases:**
  - Divu 5/0 → 0xFFFFFFFF; Remu 5/0 → 5.
  - Div 0x80000000/0xFFFFFFFF → 0x80000000; Rem → 0.
  - Latency is still 33.
- **Flush and restart:**
  - Flush at RUN iteration 10 → `busy`=0 next cycle, no `done`.
  - A start two cycles later with Mul 3×4 → 12 at +33.
- **Start while busy:**
  - A second `enable` at iteration 5 with different operands is ignored.
  - The original result is returned, and only one `done` pulse occurs.
- **Async reset:**
  - Deassert-to-assert `rst` mid-RUN → outputs 0 immediately, without a clock edge.
  - After release, a fresh Div 9/3 → 3.
